// File: rtl/board_store.sv
// board_store: 64-square chess board register file with start-position reload,
// a registered display read port and half-move pairing for the status display.
module board_store #(
    parameter int MOVE_CNT_W = 8
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [5:0]            board_change_addr,
    input  logic [3:0]            board_change_piece,
    input  logic                  board_change_enable,
    input  logic                  new_game,
    input  logic [5:0]            read_addr,
    output logic [3:0]            read_piece,
    output logic [255:0]          board_output,
    output logic                  busy,
    output logic [MOVE_CNT_W-1:0] move_count,
    output logic [5:0]            last_from,
    output logic [5:0]            last_to,
    output logic                  last_valid,
    output logic                  write_dropped
);

    typedef enum logic {IDLE, LOAD} state_t;
    typedef enum logic {FIRST, SECOND} phase_t;

    function automatic logic [2:0] backRankType(input int col);
        case (col)
            0, 7:    backRankType = 3'b100;
            1, 6:    backRankType = 3'b010;
            2, 5:    backRankType = 3'b011;
            3:       backRankType = 3'b101;
            default: backRankType = 3'b110;
        endcase
    endfunction

    function automatic logic [63:0][3:0] startBoard();
        logic [63:0][3:0] b;
        for (int sq = 0; sq < 64; sq++) begin
            case (sq / 8)
                0:       b[sq] = {1'b1, backRankType(sq % 8)};
                1:       b[sq] = 4'b1001;
                6:       b[sq] = 4'b0001;
                7:       b[sq] = {1'b0, backRankType(sq % 8)};
                default: b[sq] = 4'b0000;
            endcase
        end
        return b;
    endfunction

    localparam logic [63:0][3:0] START_BOARD = startBoard();
    localparam logic [MOVE_CNT_W-1:0] COUNT_MAX = {MOVE_CNT_W{1'b1}};

    state_t                  state_q, state_d;
    phase_t                  phase_q, phase_d;
    logic [63:0][3:0]        board_q, board_d;
    logic [5:0]              idx_q, idx_d;
    logic [5:0]              pendFrom_q, pendFrom_d;
    logic [5:0]              lastFrom_q, lastFrom_d;
    logic [5:0]              lastTo_q, lastTo_d;
    logic                    lastValid_q, lastValid_d;
    logic                    dropped_q, dropped_d;
    logic [MOVE_CNT_W-1:0]   moveCount_q, moveCount_d;
    logic [3:0]              readPiece_q;

    // new_game wins over everything, including a write in the same cycle
    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        board_d     = board_q;
        idx_d       = idx_q;
        pendFrom_d  = pendFrom_q;
        lastFrom_d  = lastFrom_q;
        lastTo_d    = lastTo_q;
        lastValid_d = lastValid_q;
        dropped_d   = dropped_q;
        moveCount_d = moveCount_q;

        if (new_game) begin
            state_d     = LOAD;
            idx_d       = 6'd0;
            moveCount_d = '0;
            lastValid_d = 1'b0;
            dropped_d   = 1'b0;
            phase_d     = FIRST;
        end else if (state_q == LOAD) begin
            board_d[idx_q] = START_BOARD[idx_q];
            idx_d          = idx_q + 6'd1;
            if (idx_q == 6'd63) begin
                state_d = IDLE;
            end
            if (board_change_enable) begin
                dropped_d = 1'b1;
            end
        end else if (board_change_enable) begin
            board_d[board_change_addr] = board_change_piece;
            if (phase_q == FIRST) begin
                pendFrom_d = board_change_addr;
                phase_d    = SECOND;
            end else begin
                lastFrom_d  = pendFrom_q;
                lastTo_d    = board_change_addr;
                lastValid_d = 1'b1;
                phase_d     = FIRST;
                if (moveCount_q != COUNT_MAX) begin
                    moveCount_d = moveCount_q + MOVE_CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q     <= IDLE;
            phase_q     <= FIRST;
            board_q     <= START_BOARD;
            idx_q       <= 6'd0;
            pendFrom_q  <= 6'd0;
            lastFrom_q  <= 6'd0;
            lastTo_q    <= 6'd0;
            lastValid_q <= 1'b0;
            dropped_q   <= 1'b0;
            moveCount_q <= '0;
            readPiece_q <= 4'b0000;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            board_q     <= board_d;
            idx_q       <= idx_d;
            pendFrom_q  <= pendFrom_d;
            lastFrom_q  <= lastFrom_d;
            lastTo_q    <= lastTo_d;
            lastValid_q <= lastValid_d;
            dropped_q   <= dropped_d;
            moveCount_q <= moveCount_d;
            readPiece_q <= board_q[read_addr];
        end
    end

    assign board_output  = board_q;
    assign busy          = (state_q == LOAD);
    assign read_piece    = readPiece_q;
    assign move_count    = moveCount_q;
    assign last_from     = lastFrom_q;
    assign last_to       = lastTo_q;
    assign last_valid    = lastValid_q;
    assign write_dropped = dropped_q;

endmodule

// File: tb/tb_board_store.sv
// tb_board_store: scoreboard bench for board_store; stimulus queues expected
// values tagged with the cycle they are due, a monitor compares them at negedge.
module tb_board_store;

    typedef enum int {
        SEL_SQ, SEL_BOARD, SEL_BUSY, SEL_MC, SEL_MCSAT,
        SEL_LF, SEL_LT, SEL_LV, SEL_WD, SEL_RP
    } sel_t;

    typedef struct {
        string        name;
        sel_t         sel;
        int           arg;
        logic [255:0] exp;
        int           due;
    } sb_item_t;

    logic         CLK = 1'b0;
    logic         RESET = 1'b0;
    logic [5:0]   changeAddr = 6'd0;
    logic [3:0]   changePiece = 4'd0;
    logic         changeEnable = 1'b0;
    logic         newGame = 1'b0;
    logic [5:0]   readAddr = 6'd0;

    logic [3:0]   readPiece, satReadPiece;
    logic [255:0] boardOutput, satBoardOutput;
    logic         busy, satBusy;
    logic [7:0]   moveCount;
    logic [1:0]   satMoveCount;
    logic [5:0]   lastFrom, lastTo, satLastFrom, satLastTo;
    logic         lastValid, writeDropped, satLastValid, satWriteDropped;

    int           cyc = 0;
    int           compared = 0;
    int           mismatched = 0;
    sb_item_t     sbQ[$];
    logic [255:0] startModel;

    board_store #(.MOVE_CNT_W(8)) dut (
        .CLK(CLK), .RESET(RESET),
        .board_change_addr(changeAddr), .board_change_piece(changePiece),
        .board_change_enable(changeEnable), .new_game(newGame),
        .read_addr(readAddr), .read_piece(readPiece),
        .board_output(boardOutput), .busy(busy), .move_count(moveCount),
        .last_from(lastFrom), .last_to(lastTo), .last_valid(lastValid),
        .write_dropped(writeDropped)
    );

    board_store #(.MOVE_CNT_W(2)) dutSat (
        .CLK(CLK), .RESET(RESET),
        .board_change_addr(changeAddr), .board_change_piece(changePiece),
        .board_change_enable(changeEnable), .new_game(newGame),
        .read_addr(readAddr), .read_piece(satReadPiece),
        .board_output(satBoardOutput), .busy(satBusy), .move_count(satMoveCount),
        .last_from(satLastFrom), .last_to(satLastTo), .last_valid(satLastValid),
        .write_dropped(satWriteDropped)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Start position written out rank by rank, square 0 in the lowest nibble
    function automatic logic [255:0] buildStart();
        logic [255:0] b;
        logic [3:0]   white;
        b = '0;
        for (int col = 0; col < 8; col++) begin
            case (col)
                0, 7:    white = 4'b0100;
                1, 6:    white = 4'b0010;
                2, 5:    white = 4'b0011;
                3:       white = 4'b0101;
                default: white = 4'b0110;
            endcase
            b[col*4 +: 4]        = white | 4'b1000;
            b[(8+col)*4 +: 4]    = 4'b1001;
            b[(48+col)*4 +: 4]   = 4'b0001;
            b[(56+col)*4 +: 4]   = white;
        end
        return b;
    endfunction

    function automatic logic [255:0] observe(input sel_t sel, input int arg);
        case (sel)
            SEL_SQ:    observe = 256'(boardOutput[arg*4 +: 4]);
            SEL_BOARD: observe = boardOutput;
            SEL_BUSY:  observe = 256'(busy);
            SEL_MC:    observe = 256'(moveCount);
            SEL_MCSAT: observe = 256'(satMoveCount);
            SEL_LF:    observe = 256'(lastFrom);
            SEL_LT:    observe = 256'(lastTo);
            SEL_LV:    observe = 256'(lastValid);
            SEL_WD:    observe = 256'(writeDropped);
            default:   observe = 256'(readPiece);
        endcase
    endfunction

    task automatic expectAt(input string name, input sel_t sel, input int arg,
                            input logic [255:0] exp, input int delay);
        sb_item_t it;
        it.name = name;
        it.sel  = sel;
        it.arg  = arg;
        it.exp  = exp;
        it.due  = cyc + delay;
        sbQ.push_back(it);
    endtask

    task automatic checkOutput(input sb_item_t it);
        logic [255:0] act;
        act = observe(it.sel, it.arg);
        compared++;
        if (act !== it.exp) begin
            mismatched++;
            $display("[TB] FAIL %s (cycle %0d): got %0h, expected %0h", it.name, cyc, act, it.exp);
        end
    endtask

    // Drives one cycle of inputs just after the rising edge
    task automatic applyStimulus(input logic en, input logic [5:0] addr,
                                 input logic [3:0] piece, input logic ng);
        @(posedge CLK);
        #1;
        changeEnable = en;
        changeAddr   = addr;
        changePiece  = piece;
        newGame      = ng;
    endtask

    always @(negedge CLK) begin
        for (int i = sbQ.size() - 1; i >= 0; i--) begin
            if (sbQ[i].due == cyc) begin
                checkOutput(sbQ[i]);
                sbQ.delete(i);
            end
        end
    end

    initial begin
        #200000;
        mismatched++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        int c;
        startModel = buildStart();
        $display("[TB] board_store scoreboard bench starting");

        repeat (3) @(posedge CLK);
        #1;
        RESET = 1'b1;
        expectAt("rst_board", SEL_BOARD, 0, startModel, 0);
        expectAt("rst_sq0", SEL_SQ, 0, 256'(4'b1100), 0);
        expectAt("rst_sq4", SEL_SQ, 4, 256'(4'b1110), 0);
        expectAt("rst_sq60", SEL_SQ, 60, 256'(4'b0110), 0);
        expectAt("rst_busy", SEL_BUSY, 0, 256'(0), 0);
        expectAt("rst_mc", SEL_MC, 0, 256'(0), 0);
        expectAt("rst_lv", SEL_LV, 0, 256'(0), 0);
        expectAt("rst_rp", SEL_RP, 0, 256'(0), 0);

        // read-during-write on an empty square, then clear it again
        readAddr = 6'd36;
        applyStimulus(1'b1, 6'd36, 4'b1001, 1'b0);
        expectAt("rdw_old", SEL_RP, 0, 256'(4'b0000), 1);
        expectAt("rdw_new", SEL_RP, 0, 256'(4'b1001), 2);
        applyStimulus(1'b1, 6'd36, 4'b0000, 1'b0);
        expectAt("pair0_mc", SEL_MC, 0, 256'(1), 1);
        expectAt("pair0_lt", SEL_LT, 0, 256'(36), 1);

        // e2-e4
        applyStimulus(1'b1, 6'd52, 4'b0000, 1'b0);
        expectAt("e2_clear", SEL_SQ, 52, 256'(4'b0000), 1);
        expectAt("e2_mc_hold", SEL_MC, 0, 256'(1), 1);
        applyStimulus(1'b1, 6'd36, 4'b0001, 1'b0);
        expectAt("e4_sq", SEL_SQ, 36, 256'(4'b0001), 1);
        expectAt("e4_mc", SEL_MC, 0, 256'(2), 1);
        expectAt("e4_lf", SEL_LF, 0, 256'(52), 1);
        expectAt("e4_lt", SEL_LT, 0, 256'(36), 1);
        expectAt("e4_lv", SEL_LV, 0, 256'(1), 1);

        // corrupt a few squares, then reload
        applyStimulus(1'b1, 6'd0, 4'b0000, 1'b0);
        applyStimulus(1'b1, 6'd63, 4'b0101, 1'b0);
        applyStimulus(1'b1, 6'd20, 4'b1110, 1'b0);
        expectAt("corrupt_sq20", SEL_SQ, 20, 256'(4'b1110), 1);
        applyStimulus(1'b0, 6'd0, 4'b0000, 1'b1);
        c = cyc;
        expectAt("load_busy_pre", SEL_BUSY, 0, 256'(0), 0);
        expectAt("load_busy_rise", SEL_BUSY, 0, 256'(1), 1);
        expectAt("load_mc_clr", SEL_MC, 0, 256'(0), 1);
        expectAt("load_lv_clr", SEL_LV, 0, 256'(0), 1);
        expectAt("load_busy_last", SEL_BUSY, 0, 256'(1), 64);
        expectAt("load_busy_fall", SEL_BUSY, 0, 256'(0), 65);
        while (cyc < c + 10) applyStimulus(1'b0, 6'd0, 4'b0000, 1'b0);
        applyStimulus(1'b1, 6'd0, 4'b0101, 1'b0);
        expectAt("midload_sq63", SEL_SQ, 63, 256'(4'b0101), 1);
        expectAt("midload_wd", SEL_WD, 0, 256'(1), 1);
        while (cyc < c + 66) applyStimulus(1'b0, 6'd0, 4'b0000, 1'b0);
        expectAt("load_board", SEL_BOARD, 0, startModel, 0);
        expectAt("load_sq0", SEL_SQ, 0, 256'(4'b1100), 0);
        expectAt("load_wd", SEL_WD, 0, 256'(1), 0);
        expectAt("load_mc", SEL_MC, 0, 256'(0), 0);

        // five move pairs: 8+i -> 16+i
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 6'(8 + i), 4'b0000, 1'b0);
            applyStimulus(1'b1, 6'(16 + i), 4'b1001, 1'b0);
            if (i == 1) expectAt("sat_mc2", SEL_MCSAT, 0, 256'(2), 1);
        end
        expectAt("pairs_mc", SEL_MC, 0, 256'(5), 1);
        expectAt("pairs_mcsat", SEL_MCSAT, 0, 256'(3), 1);
        expectAt("pairs_lf", SEL_LF, 0, 256'(12), 1);
        expectAt("pairs_lt", SEL_LT, 0, 256'(20), 1);
        expectAt("pairs_sq20", SEL_SQ, 20, 256'(4'b1001), 1);

        // corrupt high squares, reload with a coincident write, reset at idx 30
        applyStimulus(1'b1, 6'd40, 4'b1101, 1'b0);
        applyStimulus(1'b1, 6'd50, 4'b0000, 1'b0);
        applyStimulus(1'b1, 6'd16, 4'b0111, 1'b1);
        c = cyc;
        expectAt("ng_write_sq16", SEL_SQ, 16, 256'(4'b1001), 1);
        expectAt("ng_write_wd", SEL_WD, 0, 256'(0), 1);
        expectAt("ng_busy", SEL_BUSY, 0, 256'(1), 1);
        expectAt("midload_sq40", SEL_SQ, 40, 256'(4'b1101), 30);
        expectAt("midload_sq50", SEL_SQ, 50, 256'(4'b0000), 30);
        applyStimulus(1'b0, 6'd0, 4'b0000, 1'b0);
        while (cyc < c + 31) applyStimulus(1'b0, 6'd0, 4'b0000, 1'b0);
        RESET = 1'b0;
        expectAt("rst2_board", SEL_BOARD, 0, startModel, 0);
        expectAt("rst2_busy", SEL_BUSY, 0, 256'(0), 0);
        expectAt("rst2_mc", SEL_MC, 0, 256'(0), 0);
        expectAt("rst2_mcsat", SEL_MCSAT, 0, 256'(0), 0);
        expectAt("rst2_lf", SEL_LF, 0, 256'(0), 0);
        expectAt("rst2_lt", SEL_LT, 0, 256'(0), 0);
        expectAt("rst2_lv", SEL_LV, 0, 256'(0), 0);
        expectAt("rst2_wd", SEL_WD, 0, 256'(0), 0);
        expectAt("rst2_rp", SEL_RP, 0, 256'(0), 0);
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b1;
        expectAt("rst2_after_busy", SEL_BUSY, 0, 256'(0), 1);
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        #1;

        foreach (sbQ[i]) begin
            mismatched++;
            $display("[TB] FAIL %s: got no check, expected check at cycle %0d", sbQ[i].name, sbQ[i].due);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
